vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Generates 640x480@60 Hz VGA raster timing from the system clock.
- Drives the pixel coordinate counters (x, y) consumed by the downstream address generator, plus hsync/vsync/blank_n/vga_clk for the DAC.
- Counters start at the beginning of the sync pulse, so the active window begins at x = H_SYNC+H_BACK (144) and y = V_SYNC+V_BACK (35).

Parameters:
- CLK_DIV, 2, system clocks per pixel; even, >= 2 (50 MHz -> 25 MHz).
- H_SYNC, 96, hsync pulse width in pixels.
- H_BACK, 48, horizontal back porch.
- H_ACTIVE, 640, visible pixels per line.
- H_FRONT, 16, horizontal front porch.
- V_SYNC, 2, vsync pulse width in lines.
- V_BACK, 33, vertical back porch.
- V_ACTIVE, 480, visible lines.
- V_FRONT, 10, vertical front porch.

Ports:
- clk, input, 1, system clock; all logic is on its rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- x, output, 10, horizontal pixel counter, 0..H_TOTAL-1.
- y, output, 10, vertical line counter, 0..V_TOTAL-1.
- hsync, output, 1, horizontal sync, active low.
- vsync, output, 1, vertical sync, active low.
- blank_n, output, 1, high inside the active window.
- vga_clk, output, 1, pixel clock to the DAC.
- sync_n, output, 1, DAC composite sync; constant 0.
- pix_ce, output, 1, one-clk pulse each pixel advance.
- frame_start, output, 1, one-clk pulse when counters wrap to (0,0).

Behaviour:
- Derived constants: H_TOTAL = 800 and V_TOTAL = 525 (sum of the four parameters in each direction).
- Clock and reset: one clock, clk; reset rst_n is asynchronous, active-low. Assertion forces all state immediately to reset values regardless of clk.
- Reset values: div=0, x=0, y=0, hsync=0, vsync=0, blank_n=0, vga_clk=0, pix_ce=0, frame_start=0, sync_n=0.
- Divider:
  - div counts 0..CLK_DIV-1 every clk and wraps.
  - pix_ce is a registered output, high for exactly the one clk cycle in which div==CLK_DIV-1.
  - vga_clk is registered, 1 when div >= CLK_DIV/2. Counters therefore change on the vga_clk falling edge and are stable at its rising edge.
- Horizontal counter (x), on each clk edge where pix_ce is high:
  - x == H_TOTAL-1: x <= 0.
  - otherwise: x <= x+1.
- Vertical counter (y): advances only when x wraps.
  - y == V_TOTAL-1: y <= 0.
  - otherwise: y <= y+1.
- Sync and blank outputs:
  - Registered, and updated on the same edge as the counters. Each is the decode of the new counter value, so there is zero latency relative to x/y.
  - hsync = 0 iff x < H_SYNC.
  - vsync = 0 iff y < V_SYNC.
  - blank_n = 1 iff H_SYNC+H_BACK <= x < H_SYNC+H_BACK+H_ACTIVE and V_SYNC+V_BACK <= y < V_SYNC+V_BACK+V_ACTIVE, i.e. x 144..783 and y 35..514.
- frame_start: high for one clk on the edge where (x,y) becomes (0,0) from (799,524). It is not asserted on reset release.
- Counter values never exceed H_TOTAL-1 / V_TOTAL-1. No state other than the counters exists; no illegal states.
- Reset mid-frame: outputs return to reset values asynchronously. After release, counting restarts at (0,0) with div=0, and the first pix_ce occurs CLK_DIV clks after the first active clk edge.
- Arithmetic: x and y are unsigned 10-bit. div is $clog2(CLK_DIV) bits wide, minimum 1.

Optional Feature:
- Macro: VGA_SYNC_PIPE_EN.
- Defined:
  - hsync, vsync and blank_n are delayed by one additional pixel (one extra pix_ce stage) relative to x/y.
  - This aligns them with pixel data returning from one-cycle-latency frame memory addressed from x/y.
  - Reset values are unchanged (0).
  - During the first pixel after reset, the delayed outputs hold 0.
- Undefined: zero-latency decode as specified above.

Test Plan:
- Reset release: hold rst_n=0 for 5 clks, then release -> x=0, y=0, hsync=0. First pix_ce occurs 2 clks after release, and x=1 on that edge.
- Horizontal line: run one line -> hsync low for x 0..95, high for x 96..799. vga_clk toggles every clk. After x=799 the next pixel gives x=0 and y=1.
- Vertical frame: run a full frame -> vsync low for y 0..1. frame_start pulses once per 840000 clks, exactly when (799,524) -> (0,0).
- Active window: count blank_n-high pixels over one frame -> exactly 307200. First active pixel is at (144,35), last at (783,514).
- Async reset mid-frame: at (400,200), pull rst_n low between clk edges -> all outputs reach reset values before the next edge. After release, counting restarts from (0,0).
- With VGA_SYNC_PIPE_EN: hsync rises at x=97 instead of 96. blank_n first rises at (145,35) instead of (144,35); pixel count is still 307200.

Source files
------------

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 raster timing (counters, syncs, blank, pixel clock) from the system clock.
// Latency: hsync/vsync/blank_n are decoded from the new x/y on the same edge; one extra pixel when VGA_SYNC_PIPE_EN is defined.
// Backpressure: none; free-running, every pixel advance is signalled by a one-clk pix_ce pulse.
//
// Ports:
//   clk, rst_n         system clock, asynchronous active-low reset
//   x, y               pixel / line counters (0..H_TOTAL-1, 0..V_TOTAL-1), sync pulse starts at 0
//   hsync, vsync       active-low syncs
//   blank_n            high inside the visible window
//   vga_clk            pixel clock to the DAC; counters change on its falling edge
//   sync_n             DAC composite sync, tied low
//   pix_ce             one-clk pulse on the edge the counters advance
//   frame_start        one-clk pulse on the edge (x,y) wraps to (0,0)
// Optional: define VGA_SYNC_PIPE_EN to delay hsync/vsync/blank_n by one pixel, aligning
//           them with data from a one-cycle-latency frame memory addressed by x/y.

module vga_timing_gen #(
  parameter int CLK_DIV  = 2,
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int H_ACTIVE = 640,
  parameter int H_FRONT  = 16,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       hsync,
  output logic       vsync,
  output logic       blank_n,
  output logic       vga_clk,
  output logic       sync_n,
  output logic       pix_ce,
  output logic       frame_start
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
  localparam int DIV_W   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_SYNC_E = 10'(H_SYNC);
  localparam logic [9:0] V_SYNC_E = 10'(V_SYNC);
  localparam logic [9:0] H_ACT_LO = 10'(H_SYNC + H_BACK);
  localparam logic [9:0] H_ACT_HI = 10'(H_SYNC + H_BACK + H_ACTIVE);
  localparam logic [9:0] V_ACT_LO = 10'(V_SYNC + V_BACK);
  localparam logic [9:0] V_ACT_HI = 10'(V_SYNC + V_BACK + V_ACTIVE);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);

  logic [DIV_W-1:0] div;
  logic [DIV_W-1:0] div_nxt;
  logic             tick;
  logic             x_wrap;
  logic             y_wrap;
  logic [9:0]       x_nxt;
  logic [9:0]       y_nxt;
  logic [9:0]       dec_x;
  logic [9:0]       dec_y;

  assign sync_n = 1'b0;

  // tick marks the last system clock of a pixel; everything pixel-rate moves on it.
  always_comb begin
    tick    = (div == DIV_LAST);
    div_nxt = tick ? '0 : div + 1'b1;
    x_wrap  = (x == H_LAST);
    y_wrap  = (y == V_LAST);
    x_nxt   = x_wrap ? 10'd0 : x + 10'd1;
    y_nxt   = y;
    if (x_wrap) begin
      y_nxt = y_wrap ? 10'd0 : y + 10'd1;
    end
`ifdef VGA_SYNC_PIPE_EN
    // Decode the coordinate being left behind, i.e. one pixel late.
    dec_x = x;
    dec_y = y;
`else
    // Decode the coordinate being entered, so syncs line up with x/y.
    dec_x = x_nxt;
    dec_y = y_nxt;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div         <= '0;
      x           <= 10'd0;
      y           <= 10'd0;
      hsync       <= 1'b0;
      vsync       <= 1'b0;
      blank_n     <= 1'b0;
      vga_clk     <= 1'b0;
      pix_ce      <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      div         <= div_nxt;
      // High half of the divider cycle; falls together with the counter update.
      vga_clk     <= (div_nxt >= DIV_HALF);
      pix_ce      <= tick;
      frame_start <= tick && x_wrap && y_wrap;
      if (tick) begin
        x       <= x_nxt;
        y       <= y_nxt;
        hsync   <= (dec_x >= H_SYNC_E);
        vsync   <= (dec_y >= V_SYNC_E);
        blank_n <= (dec_x >= H_ACT_LO) && (dec_x < H_ACT_HI) &&
                   (dec_y >= V_ACT_LO) && (dec_y < V_ACT_HI);
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: randomized run/reset sequences against an arithmetic raster model.
// Latency: outputs sampled on the falling clk edge, half a cycle after the update.
// Backpressure: none; the DUT free-runs and the bench only observes.

module tb_vga_timing_gen;

  // Reduced geometry keeps full frames short; CLK_DIV stays at its default.
  localparam int CD = 2;
  localparam int HS = 4, HB = 3, HA = 8, HF = 2;
  localparam int VS = 2, VB = 3, VA = 5, VF = 2;
  localparam int HT = HS + HB + HA + HF;
  localparam int VT = VS + VB + VA + VF;
  localparam int FRAME_CLKS = HT * VT * CD;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] x, y;
  logic       hsync, vsync, blank_n, vga_clk, sync_n, pix_ce, frame_start;

  vga_timing_gen #(
    .CLK_DIV(CD),
    .H_SYNC(HS), .H_BACK(HB), .H_ACTIVE(HA), .H_FRONT(HF),
    .V_SYNC(VS), .V_BACK(VB), .V_ACTIVE(VA), .V_FRONT(VF)
  ) u_dut (
    .clk(clk),
    .rst_n(rst_n),
    .x(x),
    .y(y),
    .hsync(hsync),
    .vsync(vsync),
    .blank_n(blank_n),
    .vga_clk(vga_clk),
    .sync_n(sync_n),
    .pix_ce(pix_ce),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n = 0;        // clk edges since reset release
  int last_fs = -1; // n at previous frame_start
  int act = 0;      // visible pixels seen since last frame_start
  int frames = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0d expected=%0d (n=%0d)", tag, obs, exp, n);
    end
  endtask

  // Expected outputs depend only on how many clk edges elapsed since release.
  task automatic check_model();
    int  p, ex, ey, qp, qx, qy;
    bit  ce, hs, vs, bl;
    p  = n / CD;
    ex = p % HT;
    ey = (p / HT) % VT;
    ce = (n > 0) && (n % CD == 0);
`ifdef VGA_SYNC_PIPE_EN
    qp = p - 1;
`else
    qp = p;
`endif
    hs = 1'b0;
    vs = 1'b0;
    bl = 1'b0;
    if (qp >= 0) begin
      qx = qp % HT;
      qy = (qp / HT) % VT;
      hs = (qx >= HS);
      vs = (qy >= VS);
      bl = (qx >= HS + HB) && (qx < HS + HB + HA) && (qy >= VS + VB) && (qy < VS + VB + VA);
    end
    chk("x", x, ex);
    chk("y", y, ey);
    chk("pix_ce", pix_ce, ce);
    chk("vga_clk", vga_clk, ((n % CD) >= CD / 2) ? 1 : 0);
    chk("frame_start", frame_start, (ce && ex == 0 && ey == 0) ? 1 : 0);
    chk("hsync", hsync, hs);
    chk("vsync", vsync, vs);
    chk("blank_n", blank_n, bl);
    chk("sync_n", sync_n, 0);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_x"}, x, 0);
    chk({tag, "_y"}, y, 0);
    chk({tag, "_hsync"}, hsync, 0);
    chk({tag, "_vsync"}, vsync, 0);
    chk({tag, "_blank_n"}, blank_n, 0);
    chk({tag, "_vga_clk"}, vga_clk, 0);
    chk({tag, "_pix_ce"}, pix_ce, 0);
    chk({tag, "_frame_start"}, frame_start, 0);
    chk({tag, "_sync_n"}, sync_n, 0);
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      check_model();
      if (frame_start) begin
        if (last_fs >= 0) begin
          chk("frame_period", n - last_fs, FRAME_CLKS);
          chk("active_pixels", act, HA * VA);
        end
        last_fs = n;
        act = 0;
        frames++;
      end
      if (pix_ce && blank_n) act++;
    end
  endtask

  // Assert reset between edges, confirm it acts without a clock, hold, then release.
  task automatic async_reset(input int hold);
    #($urandom_range(1, 3));
    rst_n = 1'b0;
    #1;
    check_reset("async_rst");
    repeat (hold) @(posedge clk);
    @(negedge clk);
    check_reset("held_rst");
    #2;
    rst_n = 1'b1;
    n = 0;
    last_fs = -1;
    act = 0;
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check_reset("por");
    #2;
    rst_n = 1'b1;
    n = 0;

    // Three full frames uninterrupted: periods, visible-pixel totals, window edges.
    run(3 * FRAME_CLKS + 10);
    chk("frames_seen", frames, 3);

    // Random run lengths with asynchronous resets landing mid-frame.
    for (int k = 0; k < 8; k++) begin
      async_reset($urandom_range(1, 4));
      run($urandom_range(1, 2 * FRAME_CLKS));
    end
    async_reset(2);
    run(FRAME_CLKS + 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
